// File: rtl/nebula_link_tx_if.sv
// Link transmit port bundle: upstream FIFO read side, link output side and status.
// master is the transmit stage; slave is the environment around it.
interface nebula_link_tx_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CREDITS    = 4
);
  localparam int unsigned CntWidth = $clog2(CREDITS + 1);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;
  logic                  link_en;
  logic                  credit_in;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CntWidth-1:0]   credit_count;
  logic                  pkt_active;
  logic                  proto_err;
  logic                  credit_err;

  modport master (
    input  fifo_empty, fifo_rd_data, link_en, credit_in,
    output fifo_rd_en, out_valid, out_data, credit_count, pkt_active, proto_err, credit_err
  );

  modport slave (
    output fifo_empty, fifo_rd_data, link_en, credit_in,
    input  fifo_rd_en, out_valid, out_data, credit_count, pkt_active, proto_err, credit_err
  );
endinterface

// File: rtl/nebula_link_tx.sv
// Credit-based link transmitter: pops a show-ahead FIFO, spends one credit per flit,
// keeps packets atomic across link disables and flags framing/credit violations.
module nebula_link_tx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CREDITS    = 4
) (
  input  logic             clk,
  input  logic             rst,
  nebula_link_tx_if.master bus
);
  localparam int unsigned CntWidth = $clog2(CREDITS + 1);
  localparam logic [CntWidth-1:0] CreditMax = CntWidth'(CREDITS);
  localparam logic [CntWidth-1:0] CreditOne = CntWidth'(1);

  typedef enum logic {StIdle, StActive} state_e;
  typedef enum logic [1:0] {FlitHead = 2'b00, FlitBody = 2'b01, FlitTail = 2'b10,
                            FlitSingle = 2'b11} flit_type_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   credit_q, credit_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  proto_err_q, proto_err_d;
  logic                  credit_err_q, credit_err_d;
  logic                  start_ok;
  logic                  send;
  flit_type_e            flit_type;

  assign flit_type = flit_type_e'(bus.fifo_rd_data[DATA_WIDTH-1 -: 2]);

  // An open packet always drains; link_en only gates the start of a new one.
  assign start_ok       = (state_q == StActive) || bus.link_en;
  assign send           = !bus.fifo_empty && (credit_q != '0) && start_ok;
  assign bus.fifo_rd_en = send && !rst;

  always_comb begin
    state_d     = state_q;
    proto_err_d = proto_err_q;
    if (send) begin
      unique case (flit_type)
        FlitHead: begin
          if (state_q == StActive) proto_err_d = 1'b1;
          state_d = StActive;
        end
        FlitBody: begin
          if (state_q == StIdle) proto_err_d = 1'b1;
        end
        FlitTail: begin
          if (state_q == StIdle) proto_err_d = 1'b1;
          state_d = StIdle;
        end
        FlitSingle: begin
          if (state_q == StActive) proto_err_d = 1'b1;
          state_d = StIdle;
        end
      endcase
    end
  end

  // A returned credit with the counter already full is a receiver protocol error.
  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    if (send && !bus.credit_in) begin
      credit_d = credit_q - CreditOne;
    end else if (!send && bus.credit_in) begin
      if (credit_q == CreditMax) begin
        credit_err_d = 1'b1;
      end else begin
        credit_d = credit_q + CreditOne;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      credit_q     <= CreditMax;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      proto_err_q  <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      out_valid_q  <= send;
      if (send) out_data_q <= bus.fifo_rd_data;
      proto_err_q  <= proto_err_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.credit_count = credit_q;
  assign bus.pkt_active   = (state_q == StActive);
  assign bus.proto_err    = proto_err_q;
  assign bus.credit_err   = credit_err_q;
endmodule

// File: tb/tb_nebula_link_tx.sv
// Bench for nebula_link_tx: queue-backed FIFO, per-cycle behavioural model compare,
// directed scenarios with literal expectations, then constrained-random traffic.
module tb_nebula_link_tx;
  localparam int unsigned DW = 16;
  localparam int unsigned CR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nebula_link_tx_if #(.DATA_WIDTH(DW), .CREDITS(CR)) bus ();

  nebula_link_tx #(.DATA_WIDTH(DW), .CREDITS(CR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[$];
  bit            pop_pending;
  bit            gen_pkt;
  int            errors;
  int            checks;

  // Behavioural model: values the registered outputs must show at the next sample.
  int            m_cred;
  bit            m_pkt, m_perr, m_cerr, m_valid;
  logic [DW-1:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void refresh();
    bus.fifo_empty   = (fq.size() == 0);
    bus.fifo_rd_data = (fq.size() != 0) ? fq[0] : 16'hDEAD;
  endfunction

  function automatic void push(input logic [DW-1:0] f);
    fq.push_back(f);
    refresh();
  endfunction

  // Inputs change and directed checks run 2 units after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.link_en   = 1'b0;
    bus.credit_in = 1'b0;
    fq.delete();
    refresh();
    gen_pkt = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // FIFO side: honour the pop seen just before the edge.
  always @(posedge clk) begin
    #1;
    if (pop_pending && fq.size() != 0) begin
      fq.delete(0);
      refresh();
    end
    pop_pending = 1'b0;
  end

  // Compare process: check every cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    bit            send;
    logic [1:0]    ft;
    if (rst) begin
      chk("rst_rd_en", bus.fifo_rd_en, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_credit", bus.credit_count, CR);
      chk("rst_pkt_active", bus.pkt_active, 0);
      chk("rst_proto_err", bus.proto_err, 0);
      chk("rst_credit_err", bus.credit_err, 0);
      m_cred = CR; m_pkt = 0; m_perr = 0; m_cerr = 0; m_valid = 0; m_data = '0;
      pop_pending = 1'b0;
    end else begin
      send = (fq.size() != 0) && (m_cred > 0) && (m_pkt || bus.link_en);
      chk("rd_en", bus.fifo_rd_en, send);
      chk("out_valid", bus.out_valid, m_valid);
      chk("out_data", bus.out_data, m_data);
      chk("credit_count", bus.credit_count, m_cred);
      chk("pkt_active", bus.pkt_active, m_pkt);
      chk("proto_err", bus.proto_err, m_perr);
      chk("credit_err", bus.credit_err, m_cerr);
      pop_pending = bus.fifo_rd_en;
      m_valid = send;
      if (send) begin
        m_data = fq[0];
        ft = m_data[DW-1 -: 2];
        case (ft)
          2'b00: begin if (m_pkt) m_perr = 1; m_pkt = 1; end
          2'b01: begin if (!m_pkt) m_perr = 1; end
          2'b10: begin if (!m_pkt) m_perr = 1; m_pkt = 0; end
          default: begin if (m_pkt) m_perr = 1; m_pkt = 0; end
        endcase
      end
      m_cred = m_cred - int'(send) + int'(bus.credit_in);
      if (m_cred > CR) begin
        m_cred = CR;
        m_cerr = 1;
      end
    end
  end

  initial begin
    logic [DW-1:0] f;
    logic [1:0]    t;
    errors = 0;
    checks = 0;
    bus.link_en   = 1'b0;
    bus.credit_in = 1'b0;
    refresh();

    // Reset state and a single basic send.
    step(2);
    chk("init_credit", bus.credit_count, 4);
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_out_data", bus.out_data, 0);
    rst = 1'b0;
    bus.link_en = 1'b1;
    push(16'hC3A5);
    #1;
    chk("basic_rd_en", bus.fifo_rd_en, 1);
    step(1);
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_data", bus.out_data, 16'hC3A5);
    chk("basic_credit", bus.credit_count, 3);
    step(1);
    chk("basic_idle_valid", bus.out_valid, 0);
    chk("basic_hold_data", bus.out_data, 16'hC3A5);

    // Credit exhaustion, then a single returned credit releases exactly one flit.
    do_reset();
    bus.link_en = 1'b1;
    for (int i = 0; i < 6; i++) push(16'hC000 | 16'(i));
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("exh_credit", bus.credit_count, (i < 4) ? 3 - i : 0);
    end
    chk("exh_left", fq.size(), 2);
    chk("exh_rd_en_low", bus.fifo_rd_en, 0);
    bus.credit_in = 1'b1;
    step(1);
    bus.credit_in = 1'b0;
    chk("exh_credit_back", bus.credit_count, 1);
    chk("exh_no_same_cycle", fq.size(), 2);
    step(1);
    chk("exh_one_more", fq.size(), 1);
    chk("exh_data", bus.out_data, 16'hC004);
    chk("exh_credit_zero", bus.credit_count, 0);

    // Packet atomicity across a link disable.
    do_reset();
    bus.link_en = 1'b1;
    push(16'h0011); push(16'h4022); push(16'h4033); push(16'h8044); push(16'h0055);
    step(1);
    bus.link_en = 1'b0;
    chk("atom_pkt_on", bus.pkt_active, 1);
    step(3);
    chk("atom_tail_data", bus.out_data, 16'h8044);
    chk("atom_pkt_off", bus.pkt_active, 0);
    chk("atom_drained", fq.size(), 1);
    bus.credit_in = 1'b1;
    step(1);
    bus.credit_in = 1'b0;
    step(3);
    chk("atom_held", fq.size(), 1);
    chk("atom_held_valid", bus.out_valid, 0);
    bus.link_en = 1'b1;
    step(1);
    chk("atom_head2", bus.out_data, 16'h0055);
    chk("atom_pkt_on2", bus.pkt_active, 1);

    // Simultaneous send and credit return keeps the count steady.
    do_reset();
    bus.link_en = 1'b1;
    push(16'hC100); push(16'hC101);
    step(2);
    chk("sim_start_credit", bus.credit_count, 2);
    for (int i = 0; i < 10; i++) push(16'hC200 | 16'(i));
    bus.credit_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("sim_credit", bus.credit_count, 2);
      chk("sim_valid", bus.out_valid, 1);
    end
    bus.credit_in = 1'b0;
    chk("sim_all_sent", fq.size(), 0);

    // Sticky error flags.
    do_reset();
    bus.link_en = 1'b1;
    push(16'h4ABC);
    step(1);
    chk("err_proto", bus.proto_err, 1);
    chk("err_body_sent", bus.out_data, 16'h4ABC);
    bus.credit_in = 1'b1;
    step(1);
    chk("err_credit_full", bus.credit_count, 4);
    chk("err_credit_clear", bus.credit_err, 0);
    step(1);
    bus.credit_in = 1'b0;
    chk("err_credit_sat", bus.credit_count, 4);
    chk("err_credit_set", bus.credit_err, 1);
    step(3);
    chk("err_proto_sticky", bus.proto_err, 1);
    chk("err_credit_sticky", bus.credit_err, 1);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    bus.link_en = 1'b1;
    push(16'h0100); push(16'h4101); push(16'h4102); push(16'h8103);
    step(2);
    rst = 1'b1;
    #1;
    chk("mid_valid", bus.out_valid, 0);
    chk("mid_credit", bus.credit_count, 4);
    chk("mid_pkt", bus.pkt_active, 0);
    chk("mid_rd_en", bus.fifo_rd_en, 0);
    step(2);
    chk("mid_rd_en_hold", bus.fifo_rd_en, 0);
    chk("mid_no_pop", fq.size(), 2);
    do_reset();

    // Random traffic: mostly well-formed packets, occasional bad framing and resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) do_reset();
      if (fq.size() < 6 && $urandom_range(0, 2) != 0) begin
        if (gen_pkt) t = ($urandom_range(0, 2) == 0) ? 2'b10 : 2'b01;
        else t = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
        if ($urandom_range(0, 49) == 0) t = 2'($urandom_range(0, 3));
        if (t == 2'b00) gen_pkt = 1'b1;
        else if (t != 2'b01) gen_pkt = 1'b0;
        f = {t, 14'($urandom)};
        push(f);
      end
      bus.link_en   = ($urandom_range(0, 3) != 0);
      bus.credit_in = ($urandom_range(0, 2) == 0);
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
